// File: rtl/alu_result_stage_pkg.sv
// Shared types and encodings for the ALU result stage.
// Control codes, branch conditions, buffered entry layout.
package alu_result_stage_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_DEST_W = 4;

  localparam logic [3:0] ALUC_ADD = 4'd0;
  localparam logic [3:0] ALUC_SUB = 4'd1;
  localparam logic [3:0] ALUC_AND = 4'd2;
  localparam logic [3:0] ALUC_OR  = 4'd3;
  localparam logic [3:0] ALUC_XOR = 4'd4;
  localparam logic [3:0] ALUC_MUL = 4'd5;
  localparam logic [3:0] ALUC_DIV = 4'd6;
  localparam logic [3:0] ALUC_SLL = 4'd7;
  localparam logic [3:0] ALUC_SRL = 4'd8;
  localparam logic [3:0] ALUC_SRA = 4'd9;

  localparam logic [1:0] COND_BRZR = 2'b00;
  localparam logic [1:0] COND_BRNZ = 2'b01;
  localparam logic [1:0] COND_BRPL = 2'b10;
  localparam logic [1:0] COND_BRMI = 2'b11;

  typedef struct packed {
    logic [3:0]            ctrl;
    logic [ALU_DATA_W-1:0] hi;
    logic [ALU_DATA_W-1:0] lo;
    logic                  zero;
    logic                  neg;
    logic [ALU_DEST_W-1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  // MUL/DIV land in HI/LO; everything else writes a GPR.
  function automatic logic writes_gpr(
    input logic [3:0] ctrl
  );
    return !(ctrl == ALUC_MUL ||
             ctrl == ALUC_DIV);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle of ALU-side, writeback-side and branch signals.
// slave = the stage itself, master = its environment.
interface alu_result_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              iValid;
  logic              oReady;
  logic [3:0]        iCtrl;
  logic [DATA_W-1:0] iC_hi;
  logic [DATA_W-1:0] iC_lo;
  logic              iZero;
  logic              iNeg;
  logic [DEST_W-1:0] iDest;
  logic              iFlush;
  logic              oValid;
  logic              iReady;
  logic              oWrEn;
  logic [DEST_W-1:0] oDest;
  logic [DATA_W-1:0] oData;
  logic [DATA_W-1:0] oHI;
  logic [DATA_W-1:0] oLO;
  logic              oZ;
  logic              oN;
  logic              iBrEval;
  logic [1:0]        iCond;
  logic [DATA_W-1:0] iBrVal;
  logic              oCon;

  modport slave (
    input  iValid, iCtrl, iC_hi, iC_lo,
    input  iZero, iNeg, iDest, iFlush,
    input  iReady, iBrEval, iCond, iBrVal,
    output oReady, oValid, oWrEn, oDest,
    output oData, oHI, oLO, oZ, oN, oCon
  );

  modport master (
    output iValid, iCtrl, iC_hi, iC_lo,
    output iZero, iNeg, iDest, iFlush,
    output iReady, iBrEval, iCond, iBrVal,
    input  oReady, oValid, oWrEn, oDest,
    input  oData, oHI, oLO, oZ, oN, oCon
  );
endinterface

// File: rtl/alu_result_stage_result_fifo2.sv
// Two-entry in-order FIFO, head held in its own register.
// ready/valid decode only the registered state.
module result_fifo2
  import alu_result_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   valid,
  output logic   ready
);

  fifo_state_t state;
  entry_t      tail;

  assign valid = (state != FIFO_EMPTY);
  assign ready = (state != FIFO_FULL);

  // Occupancy and slot updates; a full FIFO never
  // sees push because ready gates it upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIFO_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= FIFO_EMPTY;
    end else begin
      unique case (state)
        FIFO_EMPTY: begin
          if (push) begin
            head  <= din;
            state <= FIFO_ONE;
          end
        end
        FIFO_ONE: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail  <= din;
            state <= FIFO_FULL;
          end else if (pop) begin
            state <= FIFO_EMPTY;
          end
        end
        FIFO_FULL: begin
          if (pop) begin
            head  <= tail;
            state <= FIFO_ONE;
          end
        end
        default: state <= FIFO_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result buffer behind the ALU: GPR retire, HI/LO commit,
// retired Z/N flags and the branch-condition flop.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEST_W = ALU_DEST_W
) (
  input  logic            iClk,
  input  logic            iRst,
  alu_result_if.slave     bus
);

  entry_t            din;
  entry_t            head;
  logic              f_valid;
  logic              f_ready;
  logic              push;
  logic              retire;
  logic              is_mul;
  logic              is_div;
  logic [DATA_W-1:0] br_val;
  logic [DEST_W-1:0] head_dest;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              z_q;
  logic              n_q;
  logic              con_q;

  assign din = '{
    ctrl: bus.iCtrl,
    hi:   bus.iC_hi,
    lo:   bus.iC_lo,
    zero: bus.iZero,
    neg:  bus.iNeg,
    dest: bus.iDest
  };

  // Flush kills both the incoming push and the pop.
  assign push   = bus.iValid & f_ready & ~bus.iFlush;
  assign retire = f_valid & bus.iReady & ~bus.iFlush;

  result_fifo2 u_fifo (
    .clk   (iClk),
    .rst   (iRst),
    .flush (bus.iFlush),
    .push  (push),
    .pop   (retire),
    .din   (din),
    .head  (head),
    .valid (f_valid),
    .ready (f_ready)
  );

  assign is_mul    = (head.ctrl == ALUC_MUL);
  assign is_div    = (head.ctrl == ALUC_DIV);
  assign br_val    = bus.iBrVal;
  assign head_dest = head.dest;

  assign bus.oReady = f_ready;
  assign bus.oValid = f_valid;
  assign bus.oWrEn  = f_valid &
                      writes_gpr(head.ctrl);
  assign bus.oDest  = head_dest;
  assign bus.oData  = head.lo;
  assign bus.oHI    = hi_q;
  assign bus.oLO    = lo_q;
  assign bus.oZ     = z_q;
  assign bus.oN     = n_q;
  assign bus.oCon   = con_q;

  // Commit HI/LO and the flags on the popping edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hi_q <= '0;
      lo_q <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
    end else if (retire) begin
      unique case (1'b1)
        is_mul: begin
          hi_q <= head.hi;
          lo_q <= head.lo;
        end
        is_div: begin
          lo_q <= head.hi;
          hi_q <= head.lo;
        end
        default: ;
      endcase
      z_q <= head.zero;
      n_q <= head.neg;
    end
  end

  // Branch condition, independent of the buffer.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      con_q <= 1'b0;
    end else if (bus.iBrEval) begin
      unique case (bus.iCond)
        COND_BRZR: con_q <= (br_val == '0);
        COND_BRNZ: con_q <= (br_val != '0);
        COND_BRPL: con_q <= ~br_val[DATA_W-1];
        COND_BRMI: con_q <= br_val[DATA_W-1];
        default:   con_q <= con_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + random bench for alu_result_stage.
// Reference model: a queue with capacity two.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  entry_t      q[$];
  logic [31:0] m_hi, m_lo;
  logic        m_z, m_n, m_con;

  alu_result_if #(.DATA_W(32), .DEST_W(4)) bus ();

  alu_result_stage dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("ready", 32'(bus.oReady),
        32'(q.size() < 2));
    chk("valid", 32'(bus.oValid),
        32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("dest", 32'(bus.oDest),
          32'(q[0].dest));
      chk("data", bus.oData, q[0].lo);
      chk("wren", 32'(bus.oWrEn),
          32'(q[0].ctrl != 4'd5 &&
              q[0].ctrl != 4'd6));
    end else begin
      chk("wren_idle", 32'(bus.oWrEn), 0);
    end
    chk("hi", bus.oHI, m_hi);
    chk("lo", bus.oLO, m_lo);
    chk("z", 32'(bus.oZ), 32'(m_z));
    chk("n", 32'(bus.oN), 32'(m_n));
    chk("con", 32'(bus.oCon), 32'(m_con));
  endtask

  // Advance the model with current inputs, clock once,
  // then compare at the falling edge.
  task automatic tick();
    entry_t e;
    int     n;
    n = q.size();
    if (rst) begin
      q.delete();
      m_hi = 0; m_lo = 0;
      m_z = 0; m_n = 0; m_con = 0;
    end else begin
      if (bus.iFlush) begin
        q.delete();
      end else begin
        if (n > 0 && bus.iReady) begin
          e = q.pop_front();
          if (e.ctrl == 4'd5) begin
            m_hi = e.hi; m_lo = e.lo;
          end else if (e.ctrl == 4'd6) begin
            m_lo = e.hi; m_hi = e.lo;
          end
          m_z = e.zero;
          m_n = e.neg;
        end
        if (bus.iValid && n < 2)
          q.push_back('{ctrl: bus.iCtrl,
                        hi: bus.iC_hi,
                        lo: bus.iC_lo,
                        zero: bus.iZero,
                        neg: bus.iNeg,
                        dest: bus.iDest});
      end
      if (bus.iBrEval) begin
        case (bus.iCond)
          2'd0: m_con = (bus.iBrVal == 0);
          2'd1: m_con = (bus.iBrVal != 0);
          2'd2: m_con = ($signed(bus.iBrVal) >= 0);
          default:
                m_con = ($signed(bus.iBrVal) < 0);
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic push_in(input logic [3:0] c,
                         input logic [31:0] h,
                         input logic [31:0] l,
                         input logic [3:0] d);
    bus.iValid = 1;
    bus.iCtrl  = c;
    bus.iC_hi  = h;
    bus.iC_lo  = l;
    bus.iZero  = (l == 0);
    bus.iNeg   = l[31];
    bus.iDest  = d;
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 32'(bus.oReady), 1);
    chk("rst_valid", 32'(bus.oValid), 0);
    chk("rst_wren", 32'(bus.oWrEn), 0);
    chk("rst_dest", 32'(bus.oDest), 0);
    chk("rst_data", bus.oData, 0);
    chk("rst_hi", bus.oHI, 0);
    chk("rst_lo", bus.oLO, 0);
    chk("rst_zn", 32'({bus.oZ, bus.oN}), 0);
    chk("rst_con", 32'(bus.oCon), 0);
  endtask

  initial begin
    clk = 0; rst = 1;
    tests = 0; fails = 0;
    q.delete();
    m_hi = 0; m_lo = 0;
    m_z = 0; m_n = 0; m_con = 0;
    bus.iValid = 0; bus.iCtrl = 0;
    bus.iC_hi = 0; bus.iC_lo = 0;
    bus.iZero = 0; bus.iNeg = 0;
    bus.iDest = 0; bus.iFlush = 0;
    bus.iReady = 0; bus.iBrEval = 0;
    bus.iCond = 0; bus.iBrVal = 0;
    @(negedge clk);
    tick();
    tick();
    check_reset_vals();
    rst = 0;

    // MUL retire
    bus.iReady = 1;
    push_in(4'd5, 32'h1, 32'h8000_0000, 4'd2);
    tick();
    bus.iValid = 0;
    chk("mul_wren", 32'(bus.oWrEn), 0);
    tick();
    chk("mul_hi", bus.oHI, 32'h1);
    chk("mul_lo", bus.oLO, 32'h8000_0000);

    // DIV retire
    push_in(4'd6, 32'hFFFF_FFFE, 32'h1, 4'd7);
    tick();
    bus.iValid = 0;
    tick();
    chk("div_lo", bus.oLO, 32'hFFFF_FFFE);
    chk("div_hi", bus.oHI, 32'h1);

    // Backpressure and order
    bus.iReady = 0;
    push_in(4'd0, 32'h0, 32'd5, 4'd3);
    tick();
    push_in(4'd1, 32'h0, 32'd7, 4'd4);
    tick();
    chk("bp_ready", 32'(bus.oReady), 0);
    push_in(4'd2, 32'h0, 32'd9, 4'd5);
    tick();
    chk("bp_refuse", 32'(q.size()), 2);
    bus.iValid = 0;
    bus.iReady = 1;
    chk("bp_h0", {bus.oData[27:0], bus.oDest},
        {28'd5, 4'd3});
    tick();
    chk("bp_h1", {bus.oData[27:0], bus.oDest},
        {28'd7, 4'd4});
    chk("bp_wren", 32'(bus.oWrEn), 1);
    tick();
    chk("bp_empty", 32'(bus.oValid), 0);

    // Full + pop + push, then push + pop in ONE
    bus.iReady = 0;
    push_in(4'd0, 32'h0, 32'd11, 4'd1);
    tick();
    push_in(4'd3, 32'h0, 32'd22, 4'd2);
    tick();
    bus.iReady = 1;
    push_in(4'd12, 32'h0, 32'd33, 4'd6);
    tick();
    chk("fp_dest", 32'(bus.oDest), 2);
    chk("fp_ready", 32'(bus.oReady), 1);
    tick();
    chk("one_dest", 32'(bus.oDest), 6);
    chk("one_data", bus.oData, 32'd33);
    chk("one_wren", 32'(bus.oWrEn), 1);
    bus.iValid = 0;
    tick();

    // Flush with two MULs and a same-cycle push
    bus.iReady = 0;
    push_in(4'd5, 32'hAA, 32'hBB, 4'd0);
    tick();
    tick();
    bus.iReady = 1;
    bus.iFlush = 1;
    tick();
    bus.iFlush = 0;
    bus.iValid = 0;
    chk("fl_valid", 32'(bus.oValid), 0);
    chk("fl_hi", bus.oHI, 32'h1);
    chk("fl_lo", bus.oLO, 32'hFFFF_FFFE);
    tick();

    // CON
    bus.iBrEval = 1;
    bus.iCond = 2'd0; bus.iBrVal = 0;
    tick();
    chk("brzr", 32'(bus.oCon), 1);
    bus.iCond = 2'd2;
    bus.iBrVal = 32'h8000_0000;
    tick();
    chk("brpl", 32'(bus.oCon), 0);
    bus.iCond = 2'd3;
    tick();
    chk("brmi", 32'(bus.oCon), 1);
    bus.iBrEval = 0;
    bus.iCond = 2'd2;
    tick();
    chk("hold", 32'(bus.oCon), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.iFlush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) != 0)
        push_in(4'($urandom_range(0, 15)),
                $urandom(), $urandom(),
                4'($urandom_range(0, 15)));
      else
        bus.iValid = 0;
      bus.iZero = $urandom_range(0, 1) == 1;
      bus.iReady = ($urandom_range(0, 3) != 0);
      bus.iBrEval = $urandom_range(0, 1) == 1;
      bus.iCond = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: bus.iBrVal = 0;
        1: bus.iBrVal = 32'h8000_0000;
        default: bus.iBrVal = $urandom();
      endcase
      tick();
    end
    rst = 0;
    bus.iFlush = 0;
    bus.iBrEval = 0;

    // Reset mid-stream
    bus.iReady = 0;
    push_in(4'd5, 32'h12, 32'h34, 4'd9);
    tick();
    bus.iReady = 1;
    tick();
    push_in(4'd0, 32'h0, 32'h56, 4'd8);
    bus.iReady = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    bus.iValid = 0;
    check_reset_vals();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
